uart_response_tx: RTL and testbench

- Serial transmitter for the response path of the acoustics command interface: returns command-reader responses (max-value byte, ASCII '0'/'1') to the host.
- Accepts bytes over a valid/ready handshake into a 4-entry FIFO.
- Serialises each byte as 8N1 UART, LSB first, on the tx pin.
- Sits between the command reader control/datapath and the board UART pin, in the clk domain.

---
 rtl/uart_response_tx.sv | 174 +++++++++++++++++
 tb/tb_uart_response_tx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_response_tx.sv
// -----------------------------------------------------------------------------
// uart_response_tx
//
// Sends command-reader response bytes (max-value byte, ASCII '0'/'1') back to
// the host. Bytes arrive over a valid/ready handshake and wait in a small
// FIFO. Each byte is then sent on the tx pin as an 8N1 UART frame, LSB first.
// Frames that are already queued follow each other with no idle gap.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (1..65535)
//   FIFO_DEPTH    byte buffer depth (power of two, >= 2)
//
// Ports:
//   clk         system clock
//   reset_b     asynchronous active-low reset
//   tx_data     byte to transmit; sampled only on an accepting edge
//   tx_valid    tx_data is valid this cycle
//   tx_ready    FIFO not full (taken from the registered count)
//   tx          UART serial line, idle high, registered
//   busy        a frame is in progress or the FIFO is non-empty
//   frame_done  one-cycle pulse on the final cycle of each stop bit
// -----------------------------------------------------------------------------
module uart_response_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic bit_end;

  assign full     = (count == FIFO_FULL);
  assign empty    = (count == '0);
  assign tx_ready = !full;
  assign push     = tx_valid && !full;
  assign bit_end  = (baud_cnt == BAUD_LAST);

  // The head is taken either when idle, or on the last stop-bit cycle so the
  // next start bit follows immediately.
  assign pop  = !empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign busy = (state != IDLE) || !empty;

  // NOTE: the byte storage has no reset; only pointers and count need a known
  // value, and nothing reads an entry before it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // tx and frame_done are registered here, so each is set one edge ahead of
  // the cycle it describes.
  // NOTE: all state in clocked blocks uses non-blocking assignment, so every
  // read below sees the value from before this edge.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      tx         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            shift    <= mem[rd_ptr];
            baud_cnt <= '0;
            tx       <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
              // A one-cycle stop bit is also its own final cycle.
              frame_done <= (BAUD_LAST == '0);
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt   <= baud_cnt + CNT_W'(1);
            frame_done <= ((baud_cnt + CNT_W'(1)) == BAUD_LAST);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_response_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_response_tx
//
// Drives three copies of uart_response_tx (CLKS_PER_BIT = 4, 8 and 1). Each
// scenario writes a list of bytes and records tx, frame_done and busy on every
// cycle. The recorded trace is compared with a trace built directly from the
// UART frame rules: frames start the cycle after the first write and follow
// each other back to back.
// -----------------------------------------------------------------------------
module tb_uart_response_tx;

  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       reset_b;
  logic [7:0] d   [NDUT];
  logic       v   [NDUT];
  logic       rdy [NDUT];
  logic       txl [NDUT];
  logic       bsy [NDUT];
  logic       fd  [NDUT];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [7:0] stim [16];
  int         stim_n;
  int         acc  [16];
  bit         started;
  bit         aborted;
  logic       s_tx [1024];
  logic       s_fd [1024];
  logic       s_bs [1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_response_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_c4 (
    .clk(clk), .reset_b(reset_b), .tx_data(d[0]), .tx_valid(v[0]),
    .tx_ready(rdy[0]), .tx(txl[0]), .busy(bsy[0]), .frame_done(fd[0]));

  uart_response_tx #(.CLKS_PER_BIT(8), .FIFO_DEPTH(4)) u_c8 (
    .clk(clk), .reset_b(reset_b), .tx_data(d[1]), .tx_valid(v[1]),
    .tx_ready(rdy[1]), .tx(txl[1]), .busy(bsy[1]), .frame_done(fd[1]));

  uart_response_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4)) u_c1 (
    .clk(clk), .reset_b(reset_b), .tx_data(d[2]), .tx_valid(v[2]),
    .tx_ready(rdy[2]), .tx(txl[2]), .busy(bsy[2]), .frame_done(fd[2]));

  function automatic int clks_of(input int sel);
    case (sel)
      0:       return 4;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  // Writes stim[0..stim_n-1] holding tx_valid. A byte is accepted on the edge
  // that follows a cycle where tx_ready was high; acc[i] holds that edge number.
  task automatic write_bytes(input int sel);
    int  waited;
    bit  got;
    for (int i = 0; i < stim_n; i++) begin
      d[sel] = stim[i];
      v[sel] = 1'b1;
      waited = 0;
      got    = 1'b0;
      while (!got) begin
        @(negedge clk);
        if (rdy[sel]) begin
          acc[i] = cyc + 1;
          got    = 1'b1;
          if (i == 0) started = 1'b1;
        end else begin
          waited++;
          if (waited > 2000) begin
            total++;
            $display("FAIL write_timeout dut%0d byte%0d: tx_ready stayed %0b, required 1",
                     sel, i, rdy[sel]);
            aborted = 1'b1;
            v[sel]  = 1'b0;
            return;
          end
        end
      end
      @(posedge clk);
      #1;
    end
    v[sel] = 1'b0;
  endtask

  // Cycle k is the cycle after edge acc[0]+k.
  task automatic monitor(input int sel, input int len);
    int k;
    int n0;
    wait (started || aborted);
    if (aborted) return;
    n0 = acc[0];
    k  = 0;
    while (k < len) begin
      @(negedge clk);
      k = cyc - n0;
      if (k >= 1 && k <= len) begin
        s_tx[k] = txl[sel];
        s_fd[k] = fd[sel];
        s_bs[k] = bsy[sel];
      end
    end
  endtask

  // Writes the stimulus list and compares the recorded trace with the ideal
  // back-to-back frame sequence.
  task automatic run_stream(input int sel, input string name);
    int   c;
    int   fl;
    int   len;
    int   j;
    int   pos;
    int   bad_tx;
    int   bad_fd;
    int   bad_bs;
    int   at_tx;
    int   at_fd;
    int   at_bs;
    logic e_tx;
    logic e_fd;
    logic e_bs;
    logic [7:0] b;
    c   = clks_of(sel);
    fl  = 10 * c;
    len = stim_n * fl + 2;
    started = 1'b0;
    aborted = 1'b0;
    @(posedge clk);
    #1;
    fork
      write_bytes(sel);
      monitor(sel, len);
    join
    if (aborted) return;
    bad_tx = 0; bad_fd = 0; bad_bs = 0;
    at_tx = 0;  at_fd = 0;  at_bs = 0;
    for (int k = 1; k <= len; k++) begin
      if (k <= stim_n * fl) begin
        j   = (k - 1) / fl;
        pos = ((k - 1) % fl) / c;
        b   = stim[j];
        if (pos == 0)      e_tx = 1'b0;
        else if (pos == 9) e_tx = 1'b1;
        else               e_tx = b[pos-1];
        e_fd = ((k % fl) == 0);
        e_bs = 1'b1;
      end else begin
        e_tx = 1'b1;
        e_fd = 1'b0;
        e_bs = 1'b0;
      end
      if (s_tx[k] !== e_tx && bad_tx++ == 0) at_tx = k;
      if (s_fd[k] !== e_fd && bad_fd++ == 0) at_fd = k;
      if (s_bs[k] !== e_bs && bad_bs++ == 0) at_bs = k;
    end
    total++;
    if (bad_tx == 0) passed++;
    else $display("FAIL %s tx: %0d wrong cycles, first at cycle %0d got %0b, required other value",
                  name, bad_tx, at_tx, s_tx[at_tx]);
    total++;
    if (bad_fd == 0) passed++;
    else $display("FAIL %s frame_done: %0d wrong cycles, first at cycle %0d got %0b",
                  name, bad_fd, at_fd, s_fd[at_fd]);
    total++;
    if (bad_bs == 0) passed++;
    else $display("FAIL %s busy: %0d wrong cycles, first at cycle %0d got %0b",
                  name, bad_bs, at_bs, s_bs[at_bs]);
  endtask

  task automatic test_reset;
    reset_b = 1'b0;
    #12;
    for (int s = 0; s < NDUT; s++) begin
      total++;
      if (txl[s] !== 1'b1) $display("FAIL reset_tx dut%0d: got %b, required 1", s, txl[s]);
      else passed++;
      total++;
      if (rdy[s] !== 1'b1) $display("FAIL reset_ready dut%0d: got %b, required 1", s, rdy[s]);
      else passed++;
      total++;
      if (bsy[s] !== 1'b0) $display("FAIL reset_busy dut%0d: got %b, required 0", s, bsy[s]);
      else passed++;
      total++;
      if (fd[s] !== 1'b0) $display("FAIL reset_frame_done dut%0d: got %b, required 0", s, fd[s]);
      else passed++;
    end
    @(negedge clk);
    reset_b = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_byte;
    stim[0] = 8'h30;
    stim_n  = 1;
    run_stream(0, "single_c4");
  endtask

  task automatic test_one_clk_per_bit;
    stim[0] = 8'hFF;
    stim_n  = 1;
    run_stream(2, "single_c1");
  endtask

  task automatic test_back_to_back;
    stim[0] = 8'h31;
    stim[1] = 8'h55;
    stim_n  = 2;
    run_stream(0, "back_to_back_c4");
  endtask

  task automatic test_fifo_full;
    for (int i = 0; i < 6; i++) stim[i] = 8'(i + 1);
    stim_n = 6;
    run_stream(1, "fifo_full_c8");
    if (aborted) return;
    // 0x02..0x05 go in on the next four edges; 0x06 waits until the pop at the
    // end of the first frame (edge +81) and is taken one edge later.
    total++;
    if (acc[4] - acc[0] !== 4)
      $display("FAIL fifo_fill_edge: byte 0x05 accepted %0d edges after 0x01, required 4",
               acc[4] - acc[0]);
    else passed++;
    total++;
    if (acc[5] - acc[0] !== 82)
      $display("FAIL fifo_full_wait: byte 0x06 accepted %0d edges after 0x01, required 82",
               acc[5] - acc[0]);
    else passed++;
  endtask

  task automatic test_random;
    int sels [2] = '{2, 0};
    for (int r = 0; r < 2; r++) begin
      stim_n = $urandom_range(3, 6);
      for (int i = 0; i < stim_n; i++) stim[i] = 8'($urandom);
      run_stream(sels[r], (r == 0) ? "random_c1" : "random_c4");
    end
  endtask

  task automatic test_reset_mid_frame;
    int bad;
    stim[0] = 8'hA5;
    stim[1] = 8'h11;
    stim[2] = 8'h22;
    stim_n  = 3;
    started = 1'b0;
    aborted = 1'b0;
    @(posedge clk);
    #1;
    write_bytes(0);
    if (aborted) return;
    // Cycles 17..20 carry data bit 3 of 0xA5, which is 0.
    while (cyc < acc[0] + 18) @(negedge clk);
    total++;
    if (txl[0] !== 1'b0) $display("FAIL mid_frame_bit3: tx got %b, required 0", txl[0]);
    else passed++;
    #2;
    reset_b = 1'b0;
    #1;
    total++;
    if (txl[0] !== 1'b1) $display("FAIL async_reset_tx: got %b, required 1", txl[0]);
    else passed++;
    total++;
    if (bsy[0] !== 1'b0) $display("FAIL async_reset_busy: got %b, required 0", bsy[0]);
    else passed++;
    total++;
    if (rdy[0] !== 1'b1) $display("FAIL async_reset_ready: got %b, required 1", rdy[0]);
    else passed++;
    @(negedge clk);
    reset_b = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (txl[0] !== 1'b1 || bsy[0] !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL post_reset_quiet: %0d active cycles, required 0", bad);
    else passed++;
    stim[0] = 8'h3C;
    stim_n  = 1;
    run_stream(0, "after_reset_c4");
  endtask

  initial begin
    for (int s = 0; s < NDUT; s++) begin
      d[s] = 8'h00;
      v[s] = 1'b0;
    end
    test_reset;
    test_single_byte;
    test_one_clk_per_bit;
    test_back_to_back;
    test_fifo_full;
    test_random;
    test_reset_mid_frame;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
